sudoku_engine: RTL and testbench

- Parametrised Sudoku game core for BOX×BOX boxes on an N×N grid, N = BOX*BOX.
- Puzzle is loaded serially at run time; the grid is not hard-coded.
- Givens are write-protected. The user edits through a cursor.
- The solution is verified by row/column/box rules, with no stored answer grid. The first failing unit is reported.
- Sits between the button/switch debouncers and the VGA/SSD display logic.

---
 rtl/sudoku_pkg.sv | 38 +++
 rtl/sudoku_unit_scan.sv | 101 ++++++++++
 rtl/sudoku_engine.sv | 201 ++++++++++++++++++++
 tb/tb_sudoku_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared definitions for the Sudoku game core.
//   - one-hot state encodings and the state enum
//   - error-type codes reported on Err_type
//   - box-address helpers mapping (box unit, element) to (row, col)
package sudoku_pkg;

    localparam logic [5:0] ST_IDLE      = 6'b00_0001;
    localparam logic [5:0] ST_LOAD      = 6'b00_0010;
    localparam logic [5:0] ST_EDIT      = 6'b00_0100;
    localparam logic [5:0] ST_CHECK     = 6'b00_1000;
    localparam logic [5:0] ST_CORRECT   = 6'b01_0000;
    localparam logic [5:0] ST_INCORRECT = 6'b10_0000;

    typedef enum logic [5:0] {
        StIdle      = ST_IDLE,
        StLoad      = ST_LOAD,
        StEdit      = ST_EDIT,
        StCheck     = ST_CHECK,
        StCorrect   = ST_CORRECT,
        StIncorrect = ST_INCORRECT
    } state_e;

    localparam logic [1:0] ERR_ROW = 2'd0;
    localparam logic [1:0] ERR_COL = 2'd1;
    localparam logic [1:0] ERR_BOX = 2'd2;

    // Boxes are numbered row-major; elements inside a box are row-major too.
    function automatic int unsigned box_row(input int unsigned box, input int unsigned u,
                                            input int unsigned k);
        return (u / box) * box + k / box;
    endfunction

    function automatic int unsigned box_col(input int unsigned box, input int unsigned u,
                                            input int unsigned k);
        return (u % box) * box + k % box;
    endfunction

endpackage

// File: rtl/sudoku_unit_scan.sv
// sudoku_unit_scan: walks every row, column and box one cell per cycle and
// flags the first empty or duplicated value.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i            clear counters and seen-mask
//   en_i               scanning active (one cell visited per cycle)
//   cell_val_i         value of the cell at row_o/col_o
//   row_o, col_o       address of the cell being visited
//   fail_o             current cell is empty or a duplicate within its unit
//   done_o             current cell is the last one and it passes
//   t_o, u_o           unit type and unit index of the current cell
module sudoku_unit_scan
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX = 3,
    localparam int unsigned N  = BOX * BOX,
    localparam int unsigned IW = $clog2(N),
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          en_i,
    input  logic [CW-1:0] cell_val_i,
    output logic [IW-1:0] row_o,
    output logic [IW-1:0] col_o,
    output logic          fail_o,
    output logic          done_o,
    output logic [1:0]    t_o,
    output logic [IW-1:0] u_o
);

    localparam logic [IW-1:0] Last = IW'(N - 1);

    logic [1:0]    t_q;
    logic [IW-1:0] u_q;
    logic [IW-1:0] k_q;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  val_bit;
    logic          last_k, last_u, last_t;

    always_comb begin
        val_bit = '0;
        if (cell_val_i != '0) begin
            val_bit = N'(1) << (cell_val_i - CW'(1));
        end
        last_k = (k_q == Last);
        last_u = (u_q == Last);
        last_t = (t_q == ERR_BOX);
        fail_o = en_i && ((cell_val_i == '0) || ((mask_q & val_bit) != '0));
        done_o = en_i && !fail_o && last_t && last_u && last_k;
        t_o    = t_q;
        u_o    = u_q;
    end

    always_comb begin
        case (t_q)
            ERR_ROW: begin
                row_o = u_q;
                col_o = k_q;
            end
            ERR_COL: begin
                row_o = k_q;
                col_o = u_q;
            end
            default: begin
                row_o = IW'(box_row(BOX, 32'(u_q), 32'(k_q)));
                col_o = IW'(box_col(BOX, 32'(u_q), 32'(k_q)));
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t_q    <= ERR_ROW;
            u_q    <= '0;
            k_q    <= '0;
            mask_q <= '0;
        end else if (start_i) begin
            t_q    <= ERR_ROW;
            u_q    <= '0;
            k_q    <= '0;
            mask_q <= '0;
        end else if (en_i && !fail_o && !done_o) begin
            if (last_k) begin
                // Unit finished: fresh mask for the next unit.
                k_q    <= '0;
                mask_q <= '0;
                if (last_u) begin
                    u_q <= '0;
                    t_q <= t_q + 2'd1;
                end else begin
                    u_q <= u_q + IW'(1);
                end
            end else begin
                k_q    <= k_q + IW'(1);
                mask_q <= mask_q | val_bit;
            end
        end
    end

endmodule

// File: rtl/sudoku_engine.sv
// sudoku_engine: Sudoku game core (grid storage, serial load, cursor editing,
// rule check by row/column/box scan, one-hot state outputs).
//   Clk, Reset                   clock, asynchronous active-high reset
//   Start, Ld_valid, Ld_data,
//   Ld_given                     serial row-major puzzle load
//   R, L, U, D, C, User_in       cursor moves and cell write
//   Check_req, Ack               start rule check / acknowledge result
//   Disp_row, Disp_col           display read address
//   Disp_value, Disp_given       combinational cell read
//   Cur_row, Cur_col             cursor position
//   q_Idle .. q_Incorrect        one-hot state
//   Err_type, Err_unit           first failing unit of the last check
// Build option: define SUDOKU_CURSOR_WRAP_EN to make cursor moves wrap at the
// grid edges instead of clamping.
module sudoku_engine
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX = 3,
    localparam int unsigned N  = BOX * BOX,
    localparam int unsigned IW = $clog2(N),
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Ld_valid,
    input  logic [CW-1:0] Ld_data,
    input  logic          Ld_given,
    input  logic          R,
    input  logic          L,
    input  logic          U,
    input  logic          D,
    input  logic          C,
    input  logic [CW-1:0] User_in,
    input  logic          Check_req,
    input  logic          Ack,
    input  logic [IW-1:0] Disp_row,
    input  logic [IW-1:0] Disp_col,
    output logic [CW-1:0] Disp_value,
    output logic          Disp_given,
    output logic [IW-1:0] Cur_row,
    output logic [IW-1:0] Cur_col,
    output logic          q_Idle,
    output logic          q_Load,
    output logic          q_Edit,
    output logic          q_Check,
    output logic          q_Correct,
    output logic          q_Incorrect,
    output logic [1:0]    Err_type,
    output logic [IW-1:0] Err_unit
);

    localparam int unsigned    NC       = N * N;
    localparam int unsigned    AW       = $clog2(NC);
    localparam logic [IW-1:0]  Last     = IW'(N - 1);
    localparam logic [CW-1:0]  NVal     = CW'(N);
    localparam logic [AW-1:0]  LastCell = AW'(NC - 1);

    state_e        state_q;
    logic [CW-1:0] cell_q [NC];
    logic [NC-1:0] given_q;
    logic [AW-1:0] ld_ptr_q;
    logic [IW-1:0] cur_row_q, cur_col_q;
    logic [1:0]    err_type_q;
    logic [IW-1:0] err_unit_q;

    logic [AW-1:0] cur_idx;
    logic          ld_ok;
    logic          scan_start, scan_en, scan_fail, scan_done;
    logic [IW-1:0] scan_row, scan_col, scan_u;
    logic [1:0]    scan_t;
    logic [CW-1:0] scan_val;

    function automatic logic [AW-1:0] cell_idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return AW'(32'(r) * N + 32'(c));
    endfunction

    function automatic logic [IW-1:0] step_up(input logic [IW-1:0] p);
`ifdef SUDOKU_CURSOR_WRAP_EN
        return (p == Last) ? '0 : p + IW'(1);
`else
        return (p == Last) ? p : p + IW'(1);
`endif
    endfunction

    function automatic logic [IW-1:0] step_down(input logic [IW-1:0] p);
`ifdef SUDOKU_CURSOR_WRAP_EN
        return (p == '0) ? Last : p - IW'(1);
`else
        return (p == '0) ? p : p - IW'(1);
`endif
    endfunction

    always_comb begin
        cur_idx    = cell_idx(cur_row_q, cur_col_q);
        ld_ok      = (Ld_data <= NVal);
        scan_start = (state_q == StEdit) && Check_req;
        scan_en    = (state_q == StCheck);
        scan_val   = cell_q[cell_idx(scan_row, scan_col)];
        Disp_value = cell_q[cell_idx(Disp_row, Disp_col)];
        Disp_given = given_q[cell_idx(Disp_row, Disp_col)];
    end

    sudoku_unit_scan #(
        .BOX(BOX)
    ) u_scan (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .start_i   (scan_start),
        .en_i      (scan_en),
        .cell_val_i(scan_val),
        .row_o     (scan_row),
        .col_o     (scan_col),
        .fail_o    (scan_fail),
        .done_o    (scan_done),
        .t_o       (scan_t),
        .u_o       (scan_u)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            ld_ptr_q   <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            err_type_q <= ERR_ROW;
            err_unit_q <= '0;
            given_q    <= '0;
            for (int i = 0; i < NC; i++) begin
                cell_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_q  <= StLoad;
                        ld_ptr_q <= '0;
                    end
                end
                StLoad: begin
                    if (Ld_valid) begin
                        // Out-of-range values load as an empty, editable cell.
                        cell_q[ld_ptr_q]  <= ld_ok ? Ld_data : '0;
                        given_q[ld_ptr_q] <= ld_ok && Ld_given && (Ld_data != '0);
                        ld_ptr_q          <= ld_ptr_q + AW'(1);
                        if (ld_ptr_q == LastCell) begin
                            state_q   <= StEdit;
                            cur_row_q <= '0;
                            cur_col_q <= '0;
                        end
                    end
                end
                StEdit: begin
                    if (Check_req) begin
                        state_q    <= StCheck;
                        err_type_q <= ERR_ROW;
                        err_unit_q <= '0;
                    end else if (R) begin
                        cur_col_q <= step_up(cur_col_q);
                    end else if (L) begin
                        cur_col_q <= step_down(cur_col_q);
                    end else if (U) begin
                        cur_row_q <= step_down(cur_row_q);
                    end else if (D) begin
                        cur_row_q <= step_up(cur_row_q);
                    end else if (C && !given_q[cur_idx] && (User_in <= NVal)) begin
                        cell_q[cur_idx] <= User_in;
                    end
                end
                StCheck: begin
                    if (scan_fail) begin
                        state_q    <= StIncorrect;
                        err_type_q <= scan_t;
                        err_unit_q <= scan_u;
                    end else if (scan_done) begin
                        state_q <= StCorrect;
                    end
                end
                StCorrect: begin
                    if (Ack) state_q <= StIdle;
                end
                StIncorrect: begin
                    if (Ack) state_q <= StEdit;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Cur_row     = cur_row_q;
    assign Cur_col     = cur_col_q;
    assign Err_type    = err_type_q;
    assign Err_unit    = err_unit_q;
    assign q_Idle      = (state_q == StIdle);
    assign q_Load      = (state_q == StLoad);
    assign q_Edit      = (state_q == StEdit);
    assign q_Check     = (state_q == StCheck);
    assign q_Correct   = (state_q == StCorrect);
    assign q_Incorrect = (state_q == StIncorrect);

endmodule

// File: tb/tb_sudoku_engine.sv
// tb_sudoku_engine: self-checking bench for sudoku_engine with BOX = 2 (4x4 grid).
// A behavioural model (grid array, cursor, rule checker) predicts every result.
module tb_sudoku_engine;

    localparam int unsigned BOX = 2;
    localparam int N = 4;
`ifdef SUDOKU_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    // Expected {q_Idle, q_Load, q_Edit, q_Check, q_Correct, q_Incorrect}
    localparam logic [5:0] S_IDLE      = 6'b100000;
    localparam logic [5:0] S_LOAD      = 6'b010000;
    localparam logic [5:0] S_EDIT      = 6'b001000;
    localparam logic [5:0] S_CORRECT   = 6'b000010;
    localparam logic [5:0] S_INCORRECT = 6'b000001;

    logic       Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ld_valid = 1'b0, Ld_given = 1'b0;
    logic       R = 1'b0, L = 1'b0, U = 1'b0, D = 1'b0, C = 1'b0;
    logic       Check_req = 1'b0, Ack = 1'b0;
    logic [2:0] Ld_data = '0, User_in = '0;
    logic [1:0] Disp_row = '0, Disp_col = '0;
    logic [2:0] Disp_value;
    logic       Disp_given;
    logic [1:0] Cur_row, Cur_col, Err_type, Err_unit;
    logic       q_Idle, q_Load, q_Edit, q_Check, q_Correct, q_Incorrect;
    logic [5:0] st;

    int checks = 0;
    int passes = 0;
    int m_grid [4][4];
    bit m_given[4][4];
    int m_r, m_c;
    int solved[16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};

    assign st = {q_Idle, q_Load, q_Edit, q_Check, q_Correct, q_Incorrect};

    sudoku_engine #(.BOX(BOX)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ld_valid(Ld_valid), .Ld_data(Ld_data),
        .Ld_given(Ld_given), .R(R), .L(L), .U(U), .D(D), .C(C), .User_in(User_in),
        .Check_req(Check_req), .Ack(Ack), .Disp_row(Disp_row), .Disp_col(Disp_col),
        .Disp_value(Disp_value), .Disp_given(Disp_given), .Cur_row(Cur_row),
        .Cur_col(Cur_col), .q_Idle(q_Idle), .q_Load(q_Load), .q_Edit(q_Edit),
        .q_Check(q_Check), .q_Correct(q_Correct), .q_Incorrect(q_Incorrect),
        .Err_type(Err_type), .Err_unit(Err_unit)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic model_clear;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                m_grid[r][c]  = 0;
                m_given[r][c] = 1'b0;
            end
        end
        m_r = 0;
        m_c = 0;
    endtask

    // Reference rule check: rows, then columns, then boxes; returns the first
    // bad cell's unit and how many cells were visited up to and including it.
    function automatic void model_check(output bit ok, output int et, output int eu,
                                        output int cyc);
        int r, c, v;
        bit seen[5];
        ok = 1'b1; et = 0; eu = 0; cyc = 0;
        for (int t = 0; t < 3; t++) begin
            for (int u = 0; u < N; u++) begin
                for (int s = 0; s < 5; s++) seen[s] = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (t == 0) begin r = u; c = k; end
                    else if (t == 1) begin r = k; c = u; end
                    else begin r = (u / BOX) * BOX + k / BOX; c = (u % BOX) * BOX + k % BOX; end
                    v = m_grid[r][c];
                    cyc++;
                    if (v == 0 || seen[v]) begin
                        ok = 1'b0; et = t; eu = u;
                        return;
                    end
                    seen[v] = 1'b1;
                end
            end
        end
    endfunction

    task automatic do_reset;
        @(negedge Clk);
        Reset = 1'b1;
        {Start, Ld_valid, Ld_given, R, L, U, D, C, Check_req, Ack} = '0;
        @(negedge Clk);
        Reset = 1'b0;
        model_clear();
    endtask

    task automatic check_grid(input string name);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                Disp_row = 2'(r);
                Disp_col = 2'(c);
                #1;
                checks++;
                if (Disp_value !== 3'(m_grid[r][c]) || Disp_given !== m_given[r][c])
                    $display("FAIL %s cell(%0d,%0d): got v=%0d g=%0b, expected v=%0d g=%0b",
                             name, r, c, Disp_value, Disp_given, m_grid[r][c], m_given[r][c]);
                else passes++;
            end
        end
    endtask

    task automatic load_grid(input string name, input int vals[16], input bit gv[16]);
        int v;
        Start = 1'b1; tick; Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Ld_valid = 1'b1; Ld_data = 3'(vals[i]); Ld_given = gv[i];
            tick;
            v = (vals[i] > N) ? 0 : vals[i];
            m_grid[i / 4][i % 4]  = v;
            m_given[i / 4][i % 4] = gv[i] && (v != 0);
        end
        Ld_valid = 1'b0; Ld_given = 1'b0;
        m_r = 0; m_c = 0;
        checks++;
        if (st !== S_EDIT || {Cur_row, Cur_col} !== 4'b0)
            $display("FAIL %s load-end: got state=%b cur=(%0d,%0d), expected state=%b cur=(0,0)",
                     name, st, Cur_row, Cur_col, S_EDIT);
        else passes++;
    endtask

    task automatic edit_op(input string name, input bit r, input bit l, input bit u,
                           input bit d, input bit c, input int uin);
        R = r; L = l; U = u; D = d; C = c; User_in = 3'(uin);
        tick;
        {R, L, U, D, C} = '0;
        if (r) begin
            if (m_c < N - 1) m_c++; else if (WRAP) m_c = 0;
        end else if (l) begin
            if (m_c > 0) m_c--; else if (WRAP) m_c = N - 1;
        end else if (u) begin
            if (m_r > 0) m_r--; else if (WRAP) m_r = N - 1;
        end else if (d) begin
            if (m_r < N - 1) m_r++; else if (WRAP) m_r = 0;
        end else if (c) begin
            if (!m_given[m_r][m_c] && uin <= N) m_grid[m_r][m_c] = uin;
        end
        checks++;
        if (st !== S_EDIT || {Cur_row, Cur_col} !== {2'(m_r), 2'(m_c)})
            $display("FAIL %s edit: got state=%b cur=(%0d,%0d), expected state=%b cur=(%0d,%0d)",
                     name, st, Cur_row, Cur_col, S_EDIT, m_r, m_c);
        else passes++;
    endtask

    task automatic run_check(input string name, output bit ok);
        int et, eu, cyc, n;
        model_check(ok, et, eu, cyc);
        Check_req = 1'b1; tick; Check_req = 1'b0;
        n = 0;
        while (q_Check === 1'b1 && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (n != cyc) $display("FAIL %s check-cycles: got %0d, expected %0d", name, n, cyc);
        else passes++;
        checks++;
        if (st !== (ok ? S_CORRECT : S_INCORRECT))
            $display("FAIL %s result-state: got %b, expected %b", name, st,
                     ok ? S_CORRECT : S_INCORRECT);
        else passes++;
        if (!ok) begin
            checks++;
            if ({Err_type, Err_unit} !== {2'(et), 2'(eu)})
                $display("FAIL %s err: got type=%0d unit=%0d, expected type=%0d unit=%0d",
                         name, Err_type, Err_unit, et, eu);
            else passes++;
        end
    endtask

    task automatic do_ack(input string name, input logic [5:0] exp);
        Ack = 1'b1; tick; Ack = 1'b0;
        checks++;
        if (st !== exp) $display("FAIL %s ack: got state=%b, expected %b", name, st, exp);
        else passes++;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (st !== S_IDLE || {Cur_row, Cur_col, Err_type, Err_unit} !== 8'b0)
            $display("FAIL %s reset-outs: got state=%b cur=(%0d,%0d) err=%0d/%0d, expected %b zeros",
                     name, st, Cur_row, Cur_col, Err_type, Err_unit, S_IDLE);
        else passes++;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_clear();
        check_reset_outputs("reset");
        check_grid("reset");
    endtask

    task automatic test_correct;
        bit gv[16] = '{default: 1'b0};
        bit ok;
        do_reset();
        load_grid("correct", solved, gv);
        check_grid("correct-load");
        run_check("correct", ok);
        do_ack("correct", S_IDLE);
        check_grid("correct-retained");
    endtask

    task automatic test_row_err;
        int  vals[16] = solved;
        bit  gv[16] = '{default: 1'b0};
        bit  ok;
        vals[1] = 1;
        do_reset();
        load_grid("row-err", vals, gv);
        run_check("row-err", ok);
        do_ack("row-err", S_EDIT);
        check_grid("row-err-retained");
    endtask

    task automatic test_col_err;
        int  vals[16] = solved;
        bit  gv[16] = '{default: 1'b0};
        bit  ok;
        // Row 3 becomes 4312: rows stay valid, columns 2 and 3 get duplicates.
        vals[14] = 1; vals[15] = 2;
        do_reset();
        load_grid("col-err", vals, gv);
        run_check("col-err", ok);
        checks++;
        if ({Err_type, Err_unit} !== {2'd1, 2'd2})
            $display("FAIL col-err fixed: got type=%0d unit=%0d, expected type=1 unit=2",
                     Err_type, Err_unit);
        else passes++;
        vals = solved;
        vals[9] = 0;
        do_reset();
        load_grid("zero-cell", vals, gv);
        run_check("zero-cell", ok);
        do_ack("zero-cell", S_EDIT);
    endtask

    task automatic test_edit;
        bit gv[16] = '{default: 1'b0};
        int vals[16] = solved;
        gv[2] = 1'b1;
        vals[7] = 6;
        gv[7] = 1'b1;
        do_reset();
        load_grid("edit", vals, gv);
        edit_op("edit-r1", 1, 0, 0, 0, 0, 0);
        edit_op("edit-r2", 1, 0, 0, 0, 0, 0);
        edit_op("edit-given", 0, 0, 0, 0, 1, 1);
        edit_op("edit-r3", 1, 0, 0, 0, 0, 0);
        edit_op("edit-big", 0, 0, 0, 0, 1, 5);
        edit_op("edit-d", 0, 0, 0, 1, 0, 0);
        edit_op("edit-write", 0, 0, 0, 0, 1, 4);
        check_grid("edit-a");
        edit_op("edit-clear", 0, 0, 0, 0, 1, 0);
        edit_op("edit-l", 0, 1, 0, 0, 0, 0);
        edit_op("edit-write2", 0, 0, 0, 0, 1, 1);
        check_grid("edit-b");
    endtask

    task automatic test_cursor;
        bit gv[16] = '{default: 1'b0};
        do_reset();
        load_grid("cursor", solved, gv);
        edit_op("cur-u-top", 0, 0, 1, 0, 0, 0);
        edit_op("cur-l-left", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) edit_op("cur-r", 1, 0, 0, 0, 0, 0);
        edit_op("cur-r-edge", 1, 0, 0, 0, 0, 0);
        edit_op("cur-rd", 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) edit_op("cur-d", 0, 0, 0, 1, 0, 0);
        edit_op("cur-all", 1, 1, 1, 1, 1, 2);
        check_grid("cursor");
    endtask

    task automatic test_random;
        int  vals[16];
        bit  gv[16];
        int  perm[4];
        int  j, tmp;
        bit  ok;
        int  b;
        for (int it = 0; it < 8; it++) begin
            perm = '{1, 2, 3, 4};
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 16; i++) begin
                vals[i] = perm[solved[i] - 1];
                gv[i]   = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                vals[$urandom_range(0, 15)] = $urandom_range(0, 6);
            do_reset();
            load_grid("rand-load", vals, gv);
            check_grid("rand-load");
            if (it % 2 == 1) begin
                for (int e = 0; e < 10; e++) begin
                    b = $urandom_range(0, 31);
                    edit_op("rand-edit", b[0], b[1], b[2], b[3], b[4], $urandom_range(0, 5));
                end
                check_grid("rand-edit");
            end
            run_check("rand", ok);
            do_ack("rand", ok ? S_IDLE : S_EDIT);
        end
    endtask

    task automatic test_async_reset;
        bit gv[16] = '{default: 1'b0};
        int vals[16] = solved;
        bit ok;
        // Mid-check, with the cursor away from the origin.
        do_reset();
        load_grid("arst-check", solved, gv);
        edit_op("arst-d", 0, 0, 0, 1, 0, 0);
        edit_op("arst-r", 1, 0, 0, 0, 0, 0);
        Check_req = 1'b1; tick; Check_req = 1'b0;
        repeat (10) tick;
        #2; Reset = 1'b1; #1;
        model_clear();
        check_reset_outputs("arst-check");
        check_grid("arst-check");
        @(negedge Clk); Reset = 1'b0;
        // In INCORRECT with error outputs set.
        vals[14] = 1; vals[15] = 2;
        load_grid("arst-incorrect", vals, gv);
        run_check("arst-incorrect", ok);
        #2; Reset = 1'b1; #1;
        model_clear();
        check_reset_outputs("arst-incorrect");
        @(negedge Clk); Reset = 1'b0;
        // Mid-load after 7 writes.
        Start = 1'b1; tick; Start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            Ld_valid = 1'b1; Ld_data = 3'(solved[i]); tick;
        end
        Ld_valid = 1'b0;
        checks++;
        if (st !== S_LOAD) $display("FAIL arst-load pre: got state=%b, expected %b", st, S_LOAD);
        else passes++;
        #2; Reset = 1'b1; #1;
        check_reset_outputs("arst-load");
        check_grid("arst-load");
        @(negedge Clk); Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct();
        test_row_err();
        test_col_err();
        test_edit();
        test_cursor();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
